// File: rtl/uart_pkg.sv
// Shared UART sizing constants used by the receive FIFO and its helpers.
package uart_pkg;

  localparam int UART_DATA_W     = 10;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AW    = 4;
  localparam int UART_FIFO_NW    = 5;

endpackage

// File: rtl/uart_rx_idle_timer.sv
// Idle timer for the RX FIFO: counts quiet cycles while data waits and
// raises a single registered pulse when the live limit is reached.
module uart_rx_idle_timer
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        activity_i,
  input  logic        nonempty_i,
  input  logic [15:0] limit_i,
  output logic        pulse_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        fired_q, fired_d;
  logic        pulse_q, pulse_d;

  // After firing the count freezes until activity or drain re-arms it; a
  // limit lowered below a running count is never matched because the count
  // saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    pulse_d = 1'b0;
    if (activity_i || !nonempty_i) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else if (!fired_q) begin
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
      if ((limit_i != 16'd0) && (cnt_d == limit_i)) begin
        pulse_d = 1'b1;
        fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART protocol engine and the bus side, with FWFT
// read port and interrupt pulses. Define UART_RX_FIFO_HWM_EN for high-water mark.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DW    = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW,
  parameter int NW    = UART_FIFO_NW
) (
  input  logic          pe_clk,
  input  logic          pe_rstn,
  input  logic          fifo_clr,
  input  logic          fifo_we,
  input  logic [DW-1:0] fifo_wdata,
  input  logic          fifo_re,
  output logic [DW-1:0] fifo_rdata,
  output logic [NW-1:0] fifo_num,
  output logic          fifo_empty,
  output logic          fifo_full,
  input  logic [NW-1:0] r_rx_threshold,
  input  logic [15:0]   r_timeout_cycles,
`ifdef UART_RX_FIFO_HWM_EN
  input  logic          hwm_clr,
  output logic [NW-1:0] hwm_num,
`endif
  output logic          int_status_rx_threshold,
  output logic          int_status_rx_timeout,
  output logic          int_status_rx_overflow,
  output logic          int_status_rx_underflow
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] num_q, num_d;
  logic          push, pop;
  logic          ge_now, ge_q;
  logic          thr_q, ovf_q, udf_q;

  assign fifo_empty = (num_q == '0);
  assign fifo_full  = (num_q == NW'(DEPTH));
  assign fifo_num   = num_q;
  assign fifo_rdata = fifo_empty ? '0 : mem_q[rd_ptr_q];

  // Handshake: fifo_we/fifo_re are single-cycle strobes with no backpressure;
  // a push when full is dropped (unless a pop frees the slot) and a pop when
  // empty is ignored, each reported by a pulse on the following cycle.
  always_comb begin
    push     = fifo_we & (~fifo_full | fifo_re) & ~fifo_clr;
    pop      = fifo_re & ~fifo_empty & ~fifo_clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    num_d    = num_q;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      num_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      num_d = num_q + NW'(push) - NW'(pop);
    end
  end

  always_ff @(posedge pe_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fifo_wdata;
    end
  end

  assign ge_now = (r_rx_threshold != '0) && (num_q >= r_rx_threshold);

  always_ff @(posedge pe_clk or negedge pe_rstn) begin
    if (!pe_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      num_q    <= '0;
      ge_q     <= 1'b0;
      thr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      num_q    <= num_d;
      ge_q     <= ge_now;
      thr_q    <= ge_now & ~ge_q & ~fifo_clr;
      ovf_q    <= fifo_we & fifo_full & ~fifo_re & ~fifo_clr;
      udf_q    <= fifo_re & fifo_empty & ~fifo_clr;
    end
  end

  uart_rx_idle_timer u_idle_timer (
    .clk_i      (pe_clk),
    .rst_ni     (pe_rstn),
    .activity_i (fifo_we | fifo_re | fifo_clr),
    .nonempty_i (~fifo_empty),
    .limit_i    (r_timeout_cycles),
    .pulse_o    (int_status_rx_timeout)
  );

  assign int_status_rx_threshold = thr_q;
  assign int_status_rx_overflow  = ovf_q;
  assign int_status_rx_underflow = udf_q;

`ifdef UART_RX_FIFO_HWM_EN
  logic [NW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (fifo_clr) begin
      hwm_d = '0;
    end else if (hwm_clr) begin
      hwm_d = num_q;
    end else if (num_q > hwm_q) begin
      hwm_d = num_q;
    end
  end

  always_ff @(posedge pe_clk or negedge pe_rstn) begin
    if (!pe_rstn) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm_num = hwm_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

  localparam int DW    = 10;
  localparam int NW    = 5;
  localparam int DEPTH = 16;

  logic          pe_clk = 1'b0;
  logic          pe_rstn = 1'b0;
  logic          fifo_clr = 1'b0;
  logic          fifo_we = 1'b0;
  logic [DW-1:0] fifo_wdata = '0;
  logic          fifo_re = 1'b0;
  logic [NW-1:0] r_rx_threshold = '0;
  logic [15:0]   r_timeout_cycles = '0;
  logic [DW-1:0] fifo_rdata;
  logic [NW-1:0] fifo_num;
  logic          fifo_empty, fifo_full;
  logic          int_thr, int_to, int_ovf, int_udf;
`ifdef UART_RX_FIFO_HWM_EN
  logic          hwm_clr = 1'b0;
  logic [NW-1:0] hwm_num;
`endif

  // clock / reset
  always #5 pe_clk = ~pe_clk;

  uart_rx_fifo dut (
    .pe_clk                  (pe_clk),
    .pe_rstn                 (pe_rstn),
    .fifo_clr                (fifo_clr),
    .fifo_we                 (fifo_we),
    .fifo_wdata              (fifo_wdata),
    .fifo_re                 (fifo_re),
    .fifo_rdata              (fifo_rdata),
    .fifo_num                (fifo_num),
    .fifo_empty              (fifo_empty),
    .fifo_full               (fifo_full),
    .r_rx_threshold          (r_rx_threshold),
    .r_timeout_cycles        (r_timeout_cycles),
`ifdef UART_RX_FIFO_HWM_EN
    .hwm_clr                 (hwm_clr),
    .hwm_num                 (hwm_num),
`endif
    .int_status_rx_threshold (int_thr),
    .int_status_rx_timeout   (int_to),
    .int_status_rx_overflow  (int_ovf),
    .int_status_rx_underflow (int_udf)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference model: contents as a queue, pulses derived from cycle history
  logic [DW-1:0] exp_q[$];
  int  idle_run = 0;
  bit  prev_ge = 1'b0;
  bit  exp_thr = 1'b0, exp_to = 1'b0, exp_ovf = 1'b0, exp_udf = 1'b0;
  int  m_sz;
  bit  m_ge;

  always @(posedge pe_clk or negedge pe_rstn) begin
    if (!pe_rstn) begin
      exp_q.delete();
      idle_run = 0;
      prev_ge  = 1'b0;
      exp_thr  = 1'b0;
      exp_to   = 1'b0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
    end else begin
      m_sz    = exp_q.size();
      m_ge    = (r_rx_threshold != 0) && (m_sz >= int'(r_rx_threshold));
      exp_thr = m_ge && !prev_ge && !fifo_clr;
      prev_ge = m_ge;
      exp_ovf = fifo_we && (m_sz == DEPTH) && !fifo_re && !fifo_clr;
      exp_udf = fifo_re && (m_sz == 0) && !fifo_clr;
      if (fifo_clr) begin
        exp_q.delete();
        idle_run = 0;
        exp_to   = 1'b0;
      end else begin
        if ((m_sz > 0) && !fifo_we && !fifo_re) begin
          idle_run++;
          exp_to = (r_timeout_cycles != 0) && (idle_run == int'(r_timeout_cycles));
        end else begin
          idle_run = 0;
          exp_to   = 1'b0;
        end
        if (fifo_re && (m_sz > 0)) void'(exp_q.pop_front());
        if (fifo_we && ((m_sz < DEPTH) || fifo_re)) exp_q.push_back(fifo_wdata);
      end
    end
  end

  // scoreboard compare, every cycle on the inactive edge
  always @(negedge pe_clk) begin
    if (chk_en) begin
      chk("m_num",   32'(fifo_num),   32'(exp_q.size()));
      chk("m_empty", 32'(fifo_empty), 32'(exp_q.size() == 0));
      chk("m_full",  32'(fifo_full),  32'(exp_q.size() == DEPTH));
      chk("m_rdata", 32'(fifo_rdata), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
      chk("m_thr",   32'(int_thr),    32'(exp_thr));
      chk("m_to",    32'(int_to),     32'(exp_to));
      chk("m_ovf",   32'(int_ovf),    32'(exp_ovf));
      chk("m_udf",   32'(int_udf),    32'(exp_udf));
    end
  end

  // driver tasks: called on a falling edge, return on the next falling edge
  task automatic cyc(input bit we, input logic [DW-1:0] d, input bit re, input bit clr);
    fifo_we    = we;
    fifo_wdata = d;
    fifo_re    = re;
    fifo_clr   = clr;
    @(negedge pe_clk);
    fifo_we  = 1'b0;
    fifo_re  = 1'b0;
    fifo_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_no_irq(input string tag);
    chk({tag, "_thr"}, 32'(int_thr), 32'd0);
    chk({tag, "_to"},  32'(int_to),  32'd0);
    chk({tag, "_ovf"}, 32'(int_ovf), 32'd0);
    chk({tag, "_udf"}, 32'(int_udf), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge pe_clk);
    chk("rst_num",   32'(fifo_num),   32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full",  32'(fifo_full),  32'd0);
    chk("rst_rdata", 32'(fifo_rdata), 32'd0);
    chk_no_irq("rst");
    pe_rstn = 1'b1;
    chk_en  = 1'b1;
    idle(1);

    // basic FWFT ordering
    cyc(1'b1, 10'h155, 1'b0, 1'b0);
    cyc(1'b1, 10'h2AA, 1'b0, 1'b0);
    cyc(1'b1, 10'h001, 1'b0, 1'b0);
    chk("t1_num",   32'(fifo_num),   32'd3);
    chk("t1_rdata", 32'(fifo_rdata), 32'h155);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t1_pop_rdata", 32'(fifo_rdata), 32'h2AA);
    chk("t1_pop_num",   32'(fifo_num),   32'd2);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // fill past full, then drain
    for (int i = 1; i <= 17; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 16) chk("t2_full16", 32'(fifo_full), 32'd1);
    end
    chk("t2_ovf",     32'(int_ovf),  32'd1);
    chk("t2_num_ovf", 32'(fifo_num), 32'd16);
    idle(1);
    chk("t2_ovf_once", 32'(int_ovf), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      chk("t2_drain", 32'(fifo_rdata), 32'(i));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t2_empty", 32'(fifo_empty), 32'd1);
    chk("t2_rdata0", 32'(fifo_rdata), 32'd0);

    // threshold crossing and re-arm
    r_rx_threshold = 5'd4;
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(10'h040 + i), 1'b0, 1'b0);
    chk("t3_num4",    32'(fifo_num), 32'd4);
    chk("t3_not_yet", 32'(int_thr),  32'd0);
    idle(1);
    chk("t3_pulse1", 32'(int_thr), 32'd1);
    cyc(1'b1, 10'h045, 1'b0, 1'b0);
    chk("t3_no_re1", 32'(int_thr), 32'd0);
    idle(1);
    chk("t3_no_re2", 32'(int_thr), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    chk("t3_num3", 32'(fifo_num), 32'd3);
    cyc(1'b1, 10'h046, 1'b0, 1'b0);
    idle(1);
    chk("t3_pulse2", 32'(int_thr), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    r_rx_threshold = '0;

    // idle timeout: fires once at exactly 20 idle cycles
    r_timeout_cycles = 16'd20;
    cyc(1'b1, 10'h3C3, 1'b0, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      idle(1);
      chk("t4_to", 32'(int_to), 32'(i == 20));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 10'h0C3, 1'b0, 1'b0);
    idle(9);
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      idle(1);
      chk("t4_no_to", 32'(int_to), 32'd0);
    end
    r_timeout_cycles = '0;

    // simultaneous push/pop at full and at empty
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(10'h100 + i), 1'b0, 1'b0);
    cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
    chk("t5_full_num", 32'(fifo_num),   32'd16);
    chk("t5_full_ovf", 32'(int_ovf),    32'd0);
    chk("t5_head",     32'(fifo_rdata), 32'h101);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 10'h0AB, 1'b1, 1'b0);
    chk("t5_empty_num", 32'(fifo_num),   32'd1);
    chk("t5_empty_udf", 32'(int_udf),    32'd1);
    chk("t5_rdata",     32'(fifo_rdata), 32'h0AB);
    idle(1);
    chk("t5_udf_once", 32'(int_udf), 32'd0);

    // flush with concurrent push at num=9
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, DW'(10'h200 + i), 1'b0, 1'b0);
    chk("t6_num9", 32'(fifo_num), 32'd9);
    cyc(1'b1, 10'h111, 1'b0, 1'b1);
    chk("t6_num0",  32'(fifo_num),   32'd0);
    chk("t6_empty", 32'(fifo_empty), 32'd1);
    chk_no_irq("t6a");
    idle(1);
    chk_no_irq("t6b");

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(10'h300 + i), 1'b0, 1'b0);
    fifo_we    = 1'b1;
    fifo_wdata = 10'h3AA;
    #2 pe_rstn = 1'b0;
    #1;
    chk("t7_num",   32'(fifo_num),   32'd0);
    chk("t7_empty", 32'(fifo_empty), 32'd1);
    chk("t7_full",  32'(fifo_full),  32'd0);
    chk("t7_rdata", 32'(fifo_rdata), 32'd0);
    chk_no_irq("t7");
    fifo_we = 1'b0;
    @(negedge pe_clk);
    #2 pe_rstn = 1'b1;
    @(negedge pe_clk);
    cyc(1'b1, 10'h2C5, 1'b0, 1'b0);
    chk("t7_after_num",   32'(fifo_num),   32'd1);
    chk("t7_after_rdata", 32'(fifo_rdata), 32'h2C5);
    idle(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
